// File: rtl/key_command_queue_pkg.sv
// Shared constants for the blackjack key front end: button roles and debounce FSM states.
package blackjack_pkg;

    localparam int KEY_HIT   = 0;
    localparam int KEY_STAND = 1;
    localparam int KEY_DEAL  = 2;

    typedef enum logic [1:0] {
        ST_UP,
        ST_CONF_DN,
        ST_HELD,
        ST_CONF_UP
    } deb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_command_queue_if.sv
// Command handshake between the key queue (master) and the game command decode (slave).
interface key_command_queue_if #(
    parameter int IDX_W = 2
) ();

    logic             cmd_valid;
    logic [IDX_W-1:0] cmd_index;
    logic             cmd_ready;

    modport master(output cmd_valid, output cmd_index, input cmd_ready);
    modport slave(input cmd_valid, input cmd_index, output cmd_ready);

endinterface

// File: rtl/key_command_queue_debounce.sv
// One button: two-flop synchroniser, debounce FSM and optional auto-repeat.
module key_debounce
    import blackjack_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic             sync1, sync2, s;
    deb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [RPT_W-1:0] rpt, rpt_n, rpt_inc, rpt_target;
    logic             rpt_first, rpt_first_n, press_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_UP;
            cnt       <= '0;
            rpt       <= '0;
            rpt_first <= 1'b0;
            press     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rpt       <= rpt_n;
            rpt_first <= rpt_first_n;
            press     <= press_n;
        end
    end

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; counter holds while confirming a release
    assign rpt_inc    = rpt + 1'b1;
    assign rpt_target = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rpt_n       = rpt;
        rpt_first_n = rpt_first;
        press_n     = 1'b0;
        case (state)
            ST_UP: begin
                if (s) begin
                    state_n = ST_CONF_DN;
                    cnt_n   = CNT_W'(1);
                end
            end
            ST_CONF_DN: begin
                if (!s) begin
                    state_n = ST_UP;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_n     = ST_HELD;
                    press_n     = 1'b1;
                    rpt_n       = '0;
                    rpt_first_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_n = ST_CONF_UP;
                    cnt_n   = CNT_W'(1);
                end else if (REPEAT_EN != 0) begin
                    if (rpt_inc == rpt_target) begin
                        press_n     = 1'b1;
                        rpt_n       = '0;
                        rpt_first_n = 1'b0;
                    end else begin
                        rpt_n = rpt_inc;
                    end
                end
            end
            ST_CONF_UP: begin
                if (s) begin
                    state_n = ST_HELD;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_n = ST_UP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_UP;
        endcase
    end

    assign level = (state == ST_HELD) || (state == ST_CONF_UP);

endmodule

// File: rtl/key_command_queue.sv
// Debounced key front end: per-key press events queued as a pending bitmask and
// presented lowest index first over a valid/ready handshake.
module key_command_queue
    import blackjack_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 20,
    parameter int IDX_W           = idx_width(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    key_command_queue_if.master cmd,
    output logic                overflow,
    input  logic                clr_overflow
);

    logic [NUM_KEYS-1:0] pending, pending_n, sel, accept_mask, drop;
    logic [IDX_W-1:0]    idx;
    logic                found, valid;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .key_n(KEY[g]),
            .level(key_level[g]),
            .press(key_press[g])
        );
    end

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (pending[i] && !found) begin
                sel[i] = 1'b1;
                idx    = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

    assign valid         = |pending;
    assign cmd.cmd_valid = valid;
    assign cmd.cmd_index = idx;

    // A press landing on the bit being accepted re-arms it instead of counting as a drop
    assign accept_mask = (valid && cmd.cmd_ready) ? sel : '0;
    assign drop        = key_press & pending & ~accept_mask;
    assign pending_n   = (pending & ~accept_mask) | key_press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_n;
            if (|drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_command_queue.sv
// Bench for key_command_queue: a plain-instance and an auto-repeat instance share stimulus
// and are compared every cycle against a run-length/bitmask model of the key front end.
module tb_key_command_queue;
    import blackjack_pkg::*;

    localparam int NK  = 4;
    localparam int D   = 8;
    localparam int DL  = 50;
    localparam int PER = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic [NK-1:0] KEY = '1;

    logic [NK-1:0] lvl_o[2];
    logic [NK-1:0] prs_o[2];
    logic          val_o[2];
    logic          ovf_o[2];
    logic [1:0]    idx_o[2];

    int checks = 0;
    int failures = 0;

    key_command_queue_if #(.IDX_W(2)) cif0 ();
    key_command_queue_if #(.IDX_W(2)) cif1 ();

    assign cif0.cmd_ready = cmd_ready;
    assign cif1.cmd_ready = cmd_ready;
    assign val_o[0] = cif0.cmd_valid;
    assign val_o[1] = cif1.cmd_valid;
    assign idx_o[0] = cif0.cmd_index;
    assign idx_o[1] = cif1.cmd_index;

    key_command_queue #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
        .REPEAT_DELAY(DL), .REPEAT_PERIOD(PER), .IDX_W(2)
    ) dut (
        .clk(clk), .reset(reset), .KEY(KEY), .key_level(lvl_o[0]), .key_press(prs_o[0]),
        .cmd(cif0), .overflow(ovf_o[0]), .clr_overflow(clr_overflow)
    );

    key_command_queue #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
        .REPEAT_DELAY(DL), .REPEAT_PERIOD(PER), .IDX_W(2)
    ) dut_rpt (
        .clk(clk), .reset(reset), .KEY(KEY), .key_level(lvl_o[1]), .key_press(prs_o[1]),
        .cmd(cif1), .overflow(ovf_o[1]), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a level flips after D+1 consecutive synchronised samples disagreeing with it;
    // repeats fire when stable-held cycles since the press hit DL, DL+PER, DL+2*PER, ...
    bit m_s1[2][NK], m_s2[2][NK], m_lvl[2][NK], m_prs[2][NK], m_pend[2][NK];
    int m_run[2][NK], m_hc[2][NK];
    bit m_ovf[2];

    always @(posedge clk) begin : model
        int  lo;
        bit  s, acc, ovs, stable_held;
        for (int n = 0; n < 2; n++) begin
            if (!reset) begin
                for (int k = 0; k < NK; k++) begin
                    m_s1[n][k] = 1'b1; m_s2[n][k] = 1'b1; m_lvl[n][k] = 1'b0;
                    m_prs[n][k] = 1'b0; m_pend[n][k] = 1'b0; m_run[n][k] = 0; m_hc[n][k] = 0;
                end
                m_ovf[n] = 1'b0;
            end else begin
                lo = -1;
                for (int k = 0; k < NK; k++) if (m_pend[n][k] && lo < 0) lo = k;
                ovs = 1'b0;
                for (int k = 0; k < NK; k++) begin
                    acc = (lo == k) && cmd_ready;
                    if (m_prs[n][k] && m_pend[n][k] && !acc) ovs = 1'b1;
                    m_pend[n][k] = acc ? m_prs[n][k] : (m_pend[n][k] || m_prs[n][k]);
                end
                if (ovs) m_ovf[n] = 1'b1;
                else if (clr_overflow) m_ovf[n] = 1'b0;
                for (int k = 0; k < NK; k++) begin
                    s = !m_s2[n][k];
                    stable_held = m_lvl[n][k] && (m_run[n][k] == 0);
                    m_prs[n][k] = 1'b0;
                    if (s != m_lvl[n][k]) begin
                        m_run[n][k]++;
                        if (m_run[n][k] == D + 1) begin
                            m_lvl[n][k] = s;
                            m_run[n][k] = 0;
                            if (s) begin
                                m_prs[n][k] = 1'b1;
                                m_hc[n][k] = 0;
                            end
                        end
                    end else begin
                        m_run[n][k] = 0;
                        if (stable_held && n == 1) begin
                            m_hc[n][k]++;
                            if (m_hc[n][k] == DL || (m_hc[n][k] > DL && (m_hc[n][k] - DL) % PER == 0))
                                m_prs[n][k] = 1'b1;
                        end
                    end
                    m_s2[n][k] = m_s1[n][k];
                    m_s1[n][k] = KEY[k];
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NK-1:0] el, ep;
        int lo;
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                el = '0; ep = '0; lo = -1;
                for (int k = 0; k < NK; k++) begin
                    el[k] = m_lvl[n][k];
                    ep[k] = m_prs[n][k];
                    if (m_pend[n][k] && lo < 0) lo = k;
                end
                chk($sformatf("key_level[u%0d]", n), int'(lvl_o[n]), int'(el));
                chk($sformatf("key_press[u%0d]", n), int'(prs_o[n]), int'(ep));
                chk($sformatf("cmd_valid[u%0d]", n), int'(val_o[n]), int'(lo >= 0));
                if (lo >= 0) chk($sformatf("cmd_index[u%0d]", n), int'(idx_o[n]), lo);
                chk($sformatf("overflow[u%0d]", n), int'(ovf_o[n]), int'(m_ovf[n]));
            end
        end
    end

    int prs_cnt[2][NK];
    int acc_log[$];

    always @(negedge clk) begin : monitor
        if (reset) begin
            for (int n = 0; n < 2; n++)
                for (int k = 0; k < NK; k++)
                    if (prs_o[n][k]) prs_cnt[n][k]++;
            if (val_o[0] && cmd_ready) acc_log.push_back(int'(idx_o[0]));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < NK; k++) prs_cnt[n][k] = 0;
    endtask

    // Cycles from the first sampling edge until the plain instance shows the wanted value; -1 on timeout
    task automatic wait_sig(input int k, input bit use_lvl, input bit val, output int lat);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if ((use_lvl ? lvl_o[0][k] : prs_o[0][k]) == val) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("reset_level", int'(lvl_o[0]), 0);
        chk("reset_valid", int'(val_o[0]), 0);
        chk("reset_overflow", int'(ovf_o[0]), 0);

        // single press on DEAL
        clear_counts();
        KEY[KEY_DEAL] = 1'b0;
        wait_sig(KEY_DEAL, 1'b0, 1'b1, lat);
        chk("t1_press_latency", lat, 10);
        tick(1);
        chk("t1_valid", int'(val_o[0]), 1);
        chk("t1_index", int'(idx_o[0]), 2);
        KEY[KEY_DEAL] = 1'b1;
        wait_sig(KEY_DEAL, 1'b1, 1'b0, lat);
        chk("t1_release_latency", lat, 10);
        chk("t1_press_count", prs_cnt[0][KEY_DEAL], 1);
        chk("t1_still_valid", int'(val_o[0]), 1);
        cmd_ready = 1'b1;
        tick(2);
        chk("t1_drained", int'(val_o[0]), 0);
        cmd_ready = 1'b0;

        // bouncing HIT button
        clear_counts();
        for (int t = 0; t < 6; t++) begin
            KEY[KEY_HIT] = ~KEY[KEY_HIT];
            tick(3);
        end
        chk("t2_no_bounce_press", prs_cnt[0][KEY_HIT], 0);
        KEY[KEY_HIT] = 1'b0;
        wait_sig(KEY_HIT, 1'b0, 1'b1, lat);
        chk("t2_press_latency", lat, 10);
        tick(3);
        chk("t2_press_count", prs_cnt[0][KEY_HIT], 1);
        KEY[KEY_HIT] = 1'b1;
        tick(15);
        cmd_ready = 1'b1;
        tick(3);

        // simultaneous HIT and DEAL, ready throughout
        acc_log.delete();
        KEY[KEY_DEAL] = 1'b0;
        KEY[KEY_HIT] = 1'b0;
        tick(16);
        chk("t3_accept_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("t3_first_accept", acc_log[0], 0);
            chk("t3_second_accept", acc_log[1], 2);
        end
        chk("t3_drained", int'(val_o[0]), 0);
        KEY[KEY_DEAL] = 1'b1;
        KEY[KEY_HIT] = 1'b1;
        tick(15);

        // second STAND press while the first is still pending
        cmd_ready = 1'b0;
        KEY[KEY_STAND] = 1'b0; tick(12);
        KEY[KEY_STAND] = 1'b1; tick(12);
        KEY[KEY_STAND] = 1'b0; tick(12);
        chk("t4_overflow_set", int'(ovf_o[0]), 1);
        chk("t4_valid", int'(val_o[0]), 1);
        chk("t4_index", int'(idx_o[0]), 1);
        clr_overflow = 1'b1; tick(1);
        clr_overflow = 1'b0;
        chk("t4_overflow_cleared", int'(ovf_o[0]), 0);
        KEY[KEY_STAND] = 1'b1;
        tick(15);
        cmd_ready = 1'b1;
        tick(3);
        chk("t4_drained", int'(val_o[0]), 0);

        // long HIT hold: repeat instance re-issues, plain instance does not
        clear_counts();
        KEY[KEY_HIT] = 1'b0;
        tick(195);
        KEY[KEY_HIT] = 1'b1;
        tick(15);
        chk("t5_repeat_presses", prs_cnt[1][KEY_HIT], 8);
        chk("t5_plain_presses", prs_cnt[0][KEY_HIT], 1);
        chk("t5_repeat_overflow", int'(ovf_o[1]), 0);

        // asynchronous reset while a command is presented
        cmd_ready = 1'b0;
        KEY[KEY_STAND] = 1'b0;
        wait_sig(KEY_STAND, 1'b0, 1'b1, lat);
        tick(2);
        chk("t6_valid_before", int'(val_o[0]), 1);
        reset = 1'b0;
        #1;
        chk("t6_level_async", int'(lvl_o[0]), 0);
        chk("t6_press_async", int'(prs_o[0]), 0);
        chk("t6_valid_async", int'(val_o[0]), 0);
        chk("t6_overflow_async", int'(ovf_o[0]), 0);
        tick(2);
        reset = 1'b1;
        wait_sig(KEY_STAND, 1'b0, 1'b1, lat);
        chk("t6_repress_latency", lat, 10);
        KEY[KEY_STAND] = 1'b1;
        tick(15);
        cmd_ready = 1'b1;
        tick(3);

        // randomized buttons, ready and clears
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 13) == 0) KEY[k] = ~KEY[k];
            cmd_ready = 1'($urandom_range(0, 1));
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        clr_overflow = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
